// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment counter controller.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // A divisor of 1 still needs a one-bit register.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/clk_div_tick.sv
// Prescaler that counts 0..DIV-1 while enabled and emits a one-cycle tick on DIV-1.
module clk_div_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic zero,
  output logic tick
);
  import seg_pkg::*;

  localparam int W = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_reg;

  assign tick = en && (cnt_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (zero || tick) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

endmodule

// File: rtl/seg_count_ctrl.sv
// Run/pause/clear control, ripple enables and display scan for a chain of
// external decade counters.
module seg_count_ctrl #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000,
  parameter bit WRAP     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  clear_i,
  input  logic [4*DIGITS-1:0]   cnt_data_i,
  output logic [DIGITS-1:0]     cnt_en_o,
  output logic                  cnt_clr_o,
  output logic                  ovf_o,
  output logic [1:0]            state_o,
  output logic [DIGITS-1:0]     seg_sel_o,
  output logic [3:0]            seg_digit_o,
  output logic                  seg_blank_o
);
  import seg_pkg::*;

  localparam int IW = cnt_width(DIGITS);

  state_t            state_reg, state_next;
  logic              tick, scan_tick, run, cnt_zero, tick_ok, all_nine;
  logic [DIGITS-1:0] is_nine, carry_mask, zero_above, blank_vec;
  logic [IW-1:0]     idx_reg;
  logic [DIGITS-1:0] cnt_en_reg, seg_sel_reg;
  logic              cnt_clr_reg, ovf_reg, seg_blank_reg;
  logic [3:0]        seg_digit_reg;

  // Per-digit carry and blanking terms; codes above 9 never carry.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign is_nine[gi] = (cnt_data_i[4*gi +: 4] == BCD_MAX);
    if (gi == 0) begin : g_lsd
      assign carry_mask[gi] = 1'b1;
      assign blank_vec[gi]  = 1'b0;
    end else begin : g_upper
      assign carry_mask[gi] = carry_mask[gi-1] & is_nine[gi-1];
      assign blank_vec[gi]  = zero_above[gi];
    end
    if (gi == DIGITS - 1) begin : g_msd
      assign zero_above[gi] = (cnt_data_i[4*gi +: 4] == 4'd0);
    end else begin : g_lower
      assign zero_above[gi] = (cnt_data_i[4*gi +: 4] == 4'd0) & zero_above[gi+1];
    end
  end

  assign all_nine = &is_nine;
  assign tick_ok  = tick && !clear_i && !stop_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (start_i) state_next = RUN;
        RUN: begin
          if (stop_i) begin
            state_next = PAUSE;
          end else if (tick && all_nine && !WRAP) begin
            state_next = HALT;
          end
        end
        PAUSE:   if (start_i) state_next = RUN;
        default: state_next = HALT;
      endcase
    end
  end

  always_comb begin
    state_o  = state_reg;
    run      = (state_reg == RUN);
    cnt_zero = clear_i || (state_reg == IDLE) || (state_reg == HALT);
  end

  clk_div_tick #(.DIV(TICK_DIV)) u_tick_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .zero  (cnt_zero),
    .tick  (tick)
  );

  clk_div_tick #(.DIV(SCAN_DIV)) u_scan_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .zero  (1'b0),
    .tick  (scan_tick)
  );

  // At all-9s the carry mask is already all ones, so only the halting variant suppresses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_en_reg  <= '0;
      cnt_clr_reg <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      cnt_clr_reg <= clear_i;
      ovf_reg     <= tick_ok && all_nine;
      if (tick_ok && !(all_nine && !WRAP)) begin
        cnt_en_reg <= carry_mask;
      end else begin
        cnt_en_reg <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg       <= '0;
      seg_sel_reg   <= DIGITS'(1);
      seg_digit_reg <= 4'd0;
      seg_blank_reg <= 1'b0;
    end else begin
      if (scan_tick) begin
        idx_reg <= (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + IW'(1);
      end
      seg_sel_reg   <= DIGITS'(1) << idx_reg;
      seg_digit_reg <= cnt_data_i[4*idx_reg +: 4];
      seg_blank_reg <= blank_vec[idx_reg];
    end
  end

  assign cnt_en_o    = cnt_en_reg;
  assign cnt_clr_o   = cnt_clr_reg;
  assign ovf_o       = ovf_reg;
  assign seg_sel_o   = seg_sel_reg;
  assign seg_digit_o = seg_digit_reg;
  assign seg_blank_o = seg_blank_reg;

endmodule

// File: tb/tb_seg_count_ctrl.sv
// Scoreboard bench: a wrapping instance driven by a decade-counter model and a
// halting instance fed a constant 9999.
module tb_seg_count_ctrl;

  typedef struct {
    int         cyc;
    logic [3:0] en;
    logic       ovf;
    logic       clr;
  } ev_t;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] exp;
    string       name;
  } pr_t;

  logic        clk = 1'b0;
  logic        rst_n, start_i, stop_i, clear_i;
  logic [15:0] model = 16'h0000;
  logic [15:0] h_data;
  logic        load_req;
  logic [15:0] load_val;

  logic [3:0]  cnt_en_o, seg_sel_o, seg_digit_o;
  logic        cnt_clr_o, ovf_o, seg_blank_o;
  logic [1:0]  state_o;
  logic [3:0]  h_en, h_sel, h_digit;
  logic        h_clr, h_ovf, h_blank;
  logic [1:0]  h_state;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  int  rel_cyc = 0;
  bit  end_req = 1'b0;
  ev_t ev_q[$];
  pr_t pq[$];

  seg_count_ctrl #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .WRAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i),
    .cnt_data_i(model), .cnt_en_o(cnt_en_o), .cnt_clr_o(cnt_clr_o), .ovf_o(ovf_o),
    .state_o(state_o), .seg_sel_o(seg_sel_o), .seg_digit_o(seg_digit_o),
    .seg_blank_o(seg_blank_o)
  );

  seg_count_ctrl #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .WRAP(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i),
    .cnt_data_i(h_data), .cnt_en_o(h_en), .cnt_clr_o(h_clr), .ovf_o(h_ovf),
    .state_o(h_state), .seg_sel_o(h_sel), .seg_digit_o(h_digit),
    .seg_blank_o(h_blank)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External decade counters: load > clear > per-digit increment mod 10.
  always @(posedge clk) begin
    logic [15:0] nxt;
    nxt = model;
    if (load_req) begin
      nxt = load_val;
    end else if (cnt_clr_o) begin
      nxt = 16'h0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cnt_en_o[i]) nxt[4*i +: 4] = (model[4*i +: 4] == 4'd9) ? 4'd0 : model[4*i +: 4] + 4'd1;
      end
    end
    model <= nxt;
  end

  task automatic push_ev(input int t, input logic [3:0] en, input logic ovf, input logic clr);
    ev_q.push_back('{t, en, ovf, clr});
  endtask

  task automatic push_pr(input int t, input int kind, input logic [15:0] exp, input string name);
    pr_t p;
    p.cyc = t; p.kind = kind; p.exp = exp; p.name = name;
    pq.push_back(p);
  endtask

  task automatic at_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // which: 0 start, 1 stop, 2 clear
  task automatic pulse(input int t, input int which);
    at_cyc(t);
    case (which)
      0:       start_i = 1'b1;
      1:       stop_i  = 1'b1;
      default: clear_i = 1'b1;
    endcase
    @(negedge clk);
    start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic load_at(input int t, input logic [15:0] v);
    at_cyc(t);
    load_val = v; load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Display registers at cycle k show scan index from cycle k-1; index steps every 2 cycles.
  task automatic seg_window(input int k0, input logic [15:0] val, input logic [3:0] bmask,
                            input string name);
    for (int k = k0; k < k0 + 8; k++) begin
      int ix;
      logic [3:0] sel;
      ix  = ((k - 1 - rel_cyc) / 2) % 4;
      sel = 4'b0001 << ix;
      push_pr(k, 2, {7'd0, bmask[ix], val[4*ix +: 4], sel}, name);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    pr_t p;
    logic [15:0] got;
    while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
      e = ev_q.pop_front();
      checks++; failures++;
      $display("FAIL missing_event cyc=%0d got none required en=%b ovf=%b clr=%b",
               e.cyc, e.en, e.ovf, e.clr);
    end
    if (cnt_en_o != 4'd0 || ovf_o || cnt_clr_o) begin
      checks++;
      if (ev_q.size() == 0 || ev_q[0].cyc > cyc) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d got en=%b ovf=%b clr=%b required none",
                 cyc, cnt_en_o, ovf_o, cnt_clr_o);
      end else begin
        e = ev_q.pop_front();
        if (e.en !== cnt_en_o || e.ovf !== ovf_o || e.clr !== cnt_clr_o) begin
          failures++;
          $display("FAIL event cyc=%0d got en=%b ovf=%b clr=%b required en=%b ovf=%b clr=%b",
                   cyc, cnt_en_o, ovf_o, cnt_clr_o, e.en, e.ovf, e.clr);
        end else begin
          $display("event cyc=%0d en=%b ovf=%b clr=%b ok", cyc, cnt_en_o, ovf_o, cnt_clr_o);
        end
      end
    end
    while (pq.size() > 0 && pq[0].cyc <= cyc) begin
      p = pq.pop_front();
      case (p.kind)
        0:       got = {14'd0, state_o};
        1:       got = model;
        2:       got = {7'd0, seg_blank_o, seg_digit_o, seg_sel_o};
        3:       got = {14'd0, h_state};
        4:       got = {10'd0, h_en, h_ovf, h_clr};
        default: got = {10'd0, cnt_en_o, ovf_o, cnt_clr_o};
      endcase
      checks++;
      if (p.cyc != cyc || got !== p.exp) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h required=%h", p.name, cyc, got, p.exp);
      end else begin
        $display("probe %s cyc=%0d val=%h ok", p.name, cyc, got);
      end
    end
    if (end_req) begin
      checks++;
      if (ev_q.size() != 0) begin
        failures++;
        $display("FAIL event_queue_drain got %0d pending required 0", ev_q.size());
      end
      checks++;
      if (pq.size() != 0) begin
        failures++;
        $display("FAIL probe_queue_drain got %0d pending required 0", pq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    int c, b, d, e, f;
    rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0;
    load_req = 1'b0; load_val = 16'h0000; h_data = 16'h9999;

    push_pr(3, 0, 16'h0000, "rst_state");
    push_pr(3, 5, 16'h0000, "rst_events");
    push_pr(3, 2, {7'd0, 1'b0, 4'd0, 4'b0001}, "rst_seg");
    push_pr(3, 3, 16'h0000, "rst_h_state");
    push_pr(3, 4, 16'h0000, "rst_h_out");
    @(negedge clk);
    at_cyc(4);
    rel_cyc = cyc;
    rst_n = 1'b1;

    // Count from zero, pause at prescaler 2, resume, then clear on a tick.
    c = rel_cyc + 4;
    push_ev(c + 5, 4'b0001, 1'b0, 1'b0);
    push_ev(c + 9, 4'b0001, 1'b0, 1'b0);
    push_ev(c + 13, 4'b0001, 1'b0, 1'b0);
    push_ev(c + 28, 4'b0001, 1'b0, 1'b0);
    push_ev(c + 32, 4'b0000, 1'b0, 1'b1);
    push_pr(c + 1, 0, 16'd1, "run_state");
    push_pr(c + 6, 1, 16'h0001, "value_0001");
    push_pr(c + 10, 1, 16'h0002, "value_0002");
    push_pr(c + 14, 1, 16'h0003, "value_0003");
    push_pr(c + 16, 0, 16'd2, "pause_state");
    push_pr(c + 26, 0, 16'd2, "pause_hold");
    push_pr(c + 29, 1, 16'h0004, "resume_value");
    push_pr(c + 31, 1, 16'h0004, "pre_clear_value");
    push_pr(c + 32, 0, 16'd0, "clear_state");
    push_pr(c + 33, 1, 16'h0000, "clear_value");
    pulse(c, 0);
    pulse(c + 15, 1);
    pulse(c + 26, 0);
    pulse(c + 31, 2);

    // Two-digit carry from 0019.
    b = c + 40;
    push_ev(b + 7, 4'b0011, 1'b0, 1'b0);
    push_ev(b + 11, 4'b0001, 1'b0, 1'b0);
    push_ev(b + 13, 4'b0000, 1'b0, 1'b1);
    push_pr(b + 1, 1, 16'h0019, "load_0019");
    push_pr(b + 8, 1, 16'h0020, "carry_0020");
    push_pr(b + 8, 0, 16'd1, "carry_state");
    push_pr(b + 12, 1, 16'h0021, "value_0021");
    push_pr(b + 13, 0, 16'd0, "clear2_state");
    push_pr(b + 14, 1, 16'h0000, "clear2_value");
    load_at(b, 16'h0019);
    pulse(b + 2, 0);
    pulse(b + 12, 2);

    // Overflow at 9999: wrapping instance rolls over, halting instance stops.
    d = b + 20;
    push_ev(d + 7, 4'b1111, 1'b1, 1'b0);
    push_ev(d + 11, 4'b0001, 1'b0, 1'b0);
    push_ev(d + 13, 4'b0000, 1'b0, 1'b1);
    push_pr(d + 6, 3, 16'd1, "h_run_state");
    push_pr(d + 7, 3, 16'd3, "h_halt_state");
    push_pr(d + 7, 4, {10'd0, 4'b0000, 1'b1, 1'b0}, "h_ovf_pulse");
    push_pr(d + 8, 4, {10'd0, 4'b0000, 1'b0, 1'b0}, "h_ovf_end");
    push_pr(d + 8, 1, 16'h0000, "wrap_value");
    push_pr(d + 8, 0, 16'd1, "wrap_state");
    push_pr(d + 12, 1, 16'h0001, "post_wrap_value");
    push_pr(d + 12, 3, 16'd3, "h_start_ignored");
    push_pr(d + 13, 3, 16'd0, "h_clear_state");
    push_pr(d + 13, 4, {10'd0, 4'b0000, 1'b0, 1'b1}, "h_clr_pulse");
    push_pr(d + 13, 0, 16'd0, "clear3_state");
    push_pr(d + 14, 1, 16'h0000, "clear3_value");
    load_at(d, 16'h9999);
    pulse(d + 2, 0);
    pulse(d + 10, 0);
    pulse(d + 12, 2);

    // Display scan with leading-zero blanking.
    e = d + 20;
    seg_window(e + 2, 16'h0047, 4'b1100, "seg_0047");
    seg_window(e + 12, 16'h0000, 4'b1110, "seg_0000");
    seg_window(e + 22, 16'h0105, 4'b1000, "seg_0105");
    load_at(e, 16'h0047);
    load_at(e + 10, 16'h0000);
    load_at(e + 20, 16'h0105);

    // Reset asserted mid-count while running.
    f = e + 32;
    push_pr(f + 4, 0, 16'd0, "midrst_state");
    push_pr(f + 4, 5, 16'h0000, "midrst_events");
    push_pr(f + 4, 2, {7'd0, 1'b0, 4'd0, 4'b0001}, "midrst_seg");
    pulse(f, 0);
    at_cyc(f + 3);
    #2 rst_n = 1'b0;
    at_cyc(f + 6);
    end_req = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got no finish required finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
